// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - register-file writeback arbiter with an ALU bypass and a load-result queue
module reg_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        alu_valid,
  input  logic [3:0]  alu_loc,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_loc,
  input  logic [31:0] mem_data,
  output logic        do_write,
  output logic [3:0]  write_loc,
  output logic [31:0] write_data,
  output logic [15:0] busy_mask
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Queue storage; a slot whose live bit is clear is either free or a killed
  // entry waiting to reach the head.
  logic [3:0]       q_loc  [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_live;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic alu_sel;
  logic mem_fire;
  logic push;
  logic pop;
  logic pop_live;

  // Source selection: the ALU always wins, writes to x0 are architectural no-ops,
  // and a load racing a same-cycle ALU write to the same register is the older
  // value so it is dropped rather than queued.
  always_comb begin
    alu_sel   = alu_valid && (alu_loc != 4'd0);
    mem_ready = nreset && (count < CNT_W'(DEPTH));
    mem_fire  = mem_valid && mem_ready;
    push      = mem_fire && (mem_loc != 4'd0) && !(alu_sel && (mem_loc == alu_loc));
    pop       = !alu_sel && (count != '0);
    pop_live  = pop && q_live[head];
  end

  // Pending-load scoreboard seen by the issue stage.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_live[i]) begin
        busy_mask[q_loc[i]] = 1'b1;
      end
    end
  end

  // Queue pointers, occupancy and live bits, including the ALU kill of older entries.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      q_live <= '0;
    end else begin
      if (alu_sel) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q_loc[i] == alu_loc) begin
            q_live[i] <= 1'b0;
          end
        end
      end
      if (pop) begin
        q_live[head] <= 1'b0;
        head         <= head + PTR_W'(1);
      end
      if (push) begin
        q_live[tail] <= 1'b1;
        tail         <= tail + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload slots need no reset; the live bit qualifies them.
  always_ff @(posedge clock) begin
    if (push) begin
      q_loc[tail]  <= mem_loc;
      q_data[tail] <= mem_data;
    end
  end

  // Registered write port: ALU result, else a live queue head, else idle with loc/data held.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      do_write   <= 1'b0;
      write_loc  <= 4'd0;
      write_data <= 32'd0;
    end else if (alu_sel) begin
      do_write   <= 1'b1;
      write_loc  <= alu_loc;
      write_data <= alu_data;
    end else if (pop_live) begin
      do_write   <= 1'b1;
      write_loc  <= q_loc[head];
      write_data <= q_data[head];
    end else begin
      do_write   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - directed self-checking bench for reg_writeback
module tb_reg_writeback;

  logic        clock;
  logic        nreset;
  logic        alu_valid;
  logic [3:0]  alu_loc;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_loc;
  logic [31:0] mem_data;
  logic        do_write;
  logic [3:0]  write_loc;
  logic [31:0] write_data;
  logic [15:0] busy_mask;

  int n_assert = 0;
  int n_fail   = 0;

  reg_writeback #(.DEPTH(4)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .alu_valid  (alu_valid),
    .alu_loc    (alu_loc),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_loc    (mem_loc),
    .mem_data   (mem_data),
    .do_write   (do_write),
    .write_loc  (write_loc),
    .write_data (write_data),
    .busy_mask  (busy_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic dw, input logic [3:0] loc, input logic [31:0] data);
    chk({tag, ".do_write"}, 32'(do_write), 32'(dw));
    chk({tag, ".write_loc"}, 32'(write_loc), 32'(loc));
    chk({tag, ".write_data"}, write_data, data);
  endtask

  initial begin
    nreset    = 1'b0;
    alu_valid = 1'b0;
    alu_loc   = 4'd0;
    alu_data  = 32'd0;
    mem_valid = 1'b0;
    mem_loc   = 4'd0;
    mem_data  = 32'd0;

    // reset state
    tick();
    tick();
    chk_wr("reset", 1'b0, 4'd0, 32'd0);
    chk("reset.busy_mask", 32'(busy_mask), 32'h0);
    chk("reset.mem_ready", 32'(mem_ready), 32'd0);
    nreset = 1'b1;
    #1;
    chk("post_reset.mem_ready", 32'(mem_ready), 32'd1);

    // ALU x5=0x11, idle queue
    alu_valid = 1'b1; alu_loc = 4'd5; alu_data = 32'h11;
    tick();
    chk_wr("alu_x5", 1'b1, 4'd5, 32'h11);
    alu_valid = 1'b0;
    tick();
    chk_wr("alu_x5_idle_hold", 1'b0, 4'd5, 32'h11);

    // back-to-back loads x3=0xA, x4=0xB
    mem_valid = 1'b1; mem_loc = 4'd3; mem_data = 32'hA;
    tick();
    chk("ld3.busy_mask", 32'(busy_mask), 32'h0008);
    chk("ld3.do_write", 32'(do_write), 32'd0);
    mem_loc = 4'd4; mem_data = 32'hB;
    tick();
    chk_wr("wr_x3", 1'b1, 4'd3, 32'hA);
    chk("ld4.busy_mask", 32'(busy_mask), 32'h0010);
    mem_valid = 1'b0;
    tick();
    chk_wr("wr_x4", 1'b1, 4'd4, 32'hB);
    chk("ld34_drained.busy_mask", 32'(busy_mask), 32'h0);
    tick();
    chk("ld34_idle.do_write", 32'(do_write), 32'd0);

    // 4 loads starved by continuous ALU traffic to x1
    alu_valid = 1'b1; alu_loc = 4'd1;
    mem_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("fill.mem_ready_before", 32'(mem_ready), 32'd1);
      alu_data = 32'(k);
      mem_loc  = 4'(8 + k);
      mem_data = 32'h80 + 32'(k);
      tick();
      chk_wr("fill.alu_x1", 1'b1, 4'd1, 32'(k));
    end
    chk("full.mem_ready", 32'(mem_ready), 32'd0);
    chk("full.busy_mask", 32'(busy_mask), 32'h0F00);
    mem_loc = 4'd12; mem_data = 32'hDEAD;
    alu_data = 32'h77;
    tick();
    chk_wr("full_stall.alu_x1", 1'b1, 4'd1, 32'h77);
    chk("full_stall.mem_ready", 32'(mem_ready), 32'd0);
    chk("full_stall.busy_mask", 32'(busy_mask), 32'h0F00);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    tick();
    chk_wr("drain0", 1'b1, 4'd8, 32'h80);
    chk("drain0.mem_ready", 32'(mem_ready), 32'd1);
    tick();
    chk_wr("drain1", 1'b1, 4'd9, 32'h81);
    tick();
    chk_wr("drain2", 1'b1, 4'd10, 32'h82);
    tick();
    chk_wr("drain3", 1'b1, 4'd11, 32'h83);
    chk("drain3.busy_mask", 32'(busy_mask), 32'h0);
    tick();
    chk("drained.do_write", 32'(do_write), 32'd0);

    // queued load x7=1 killed by ALU x7=2
    mem_valid = 1'b1; mem_loc = 4'd7; mem_data = 32'h1;
    tick();
    chk("ld7.busy_mask", 32'(busy_mask), 32'h0080);
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_loc = 4'd7; alu_data = 32'h2;
    tick();
    chk_wr("kill.alu_x7", 1'b1, 4'd7, 32'h2);
    chk("kill.busy_mask", 32'(busy_mask), 32'h0);
    alu_valid = 1'b0;
    tick();
    chk("killed_pop.do_write", 32'(do_write), 32'd0);
    chk("killed_pop.mem_ready", 32'(mem_ready), 32'd1);
    tick();
    chk("after_kill.do_write", 32'(do_write), 32'd0);

    // x0 load and x0 ALU: handshake consumed, nothing written
    mem_valid = 1'b1; mem_loc = 4'd0; mem_data = 32'h55;
    alu_valid = 1'b1; alu_loc = 4'd0; alu_data = 32'h66;
    #1;
    chk("x0.mem_ready", 32'(mem_ready), 32'd1);
    tick();
    chk("x0.do_write", 32'(do_write), 32'd0);
    chk("x0.busy_mask", 32'(busy_mask), 32'h0);
    chk("x0.mem_ready_after", 32'(mem_ready), 32'd1);
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    tick();
    chk("x0_idle.do_write", 32'(do_write), 32'd0);

    // same-cycle load and ALU to x9: load is older and discarded
    mem_valid = 1'b1; mem_loc = 4'd9; mem_data = 32'h88;
    alu_valid = 1'b1; alu_loc = 4'd9; alu_data = 32'h99;
    tick();
    chk_wr("race_x9", 1'b1, 4'd9, 32'h99);
    chk("race_x9.busy_mask", 32'(busy_mask), 32'h0);
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    tick();
    chk("race_x9_after.do_write", 32'(do_write), 32'd0);

    // reset with three entries queued
    alu_valid = 1'b1; alu_loc = 4'd2;
    mem_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      alu_data = 32'h200 + 32'(k);
      mem_loc  = 4'(12 + k);
      mem_data = 32'hC0 + 32'(k);
      tick();
    end
    chk("pre_reset.busy_mask", 32'(busy_mask), 32'h7000);
    chk_wr("pre_reset.alu_x2", 1'b1, 4'd2, 32'h202);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    nreset    = 1'b0;
    #1;
    chk("in_reset.mem_ready", 32'(mem_ready), 32'd0);
    tick();
    chk_wr("mid_reset", 1'b0, 4'd0, 32'd0);
    chk("mid_reset.busy_mask", 32'(busy_mask), 32'h0);
    nreset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_mid_reset.do_write", 32'(do_write), 32'd0);
    end
    chk("post_mid_reset.mem_ready", 32'(mem_ready), 32'd1);
    chk("post_mid_reset.busy_mask", 32'(busy_mask), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of memory-result queue entries (power of two, 2..8).
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port nreset  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port alu_valid  input  1  a single-cycle ALU result is presented this cycle; it is always accepted.
REQ-005 SHALL have port alu_loc  input  4  ALU destination register index.
REQ-006 SHALL have port alu_data  input  32  ALU result value.
REQ-007 SHALL have port mem_valid  input  1  a load result is presented; it is held stable until accepted.
REQ-008 SHALL have port mem_ready  output  1  queue can accept a load result; handshake completes when mem_valid and mem_ready are both 1.
REQ-009 SHALL have port mem_loc  input  4  load destination register index.
REQ-010 SHALL have port mem_data  input  32  load result value.
REQ-011 SHALL have port do_write  output  1  register-file write strobe (front end of the executor write port).
REQ-012 SHALL have port write_loc  output  4  register-file write index.
REQ-013 SHALL have port write_data  output  32  register-file write value.
REQ-014 SHALL have port busy_mask  output  16  bit n = 1 while a queued, not-yet-issued load write to xn is pending.

Function
REQ-015 SHALL drive do_write, write_loc and write_data from registers: one write per cycle, issued on the cycle after the chosen source is selected.
REQ-016 SHALL give the ALU strict priority: if alu_valid=1 and alu_loc!=0, the next cycle's registered write is the ALU result.
REQ-017 SHALL, when no ALU write is selected and the queue holds a live entry, pop the oldest live entry and register it as the next write.
REQ-018 SHALL register do_write=0 when neither source is selected; write_loc and write_data hold their previous values.
REQ-019 SHALL store each accepted load result (loc, data) at the queue tail in arrival order; queue entries carry a live bit.
REQ-020 SHALL drive mem_ready=1 exactly when occupancy (live plus killed entries not yet popped) < DEPTH; push and pop in the same cycle at full is not allowed, so mem_ready is not lowered by same-cycle pops.
REQ-021 SHALL accept load results with mem_loc=0, consuming the handshake, but never issue them; they occupy no queue slot.
REQ-022 SHALL treat alu_valid with alu_loc=0 as no ALU write; it does not block the queue.
REQ-023 SHALL, when an ALU write to loc L is selected, clear the live bit of every queued entry with loc L in that cycle, since those are older and must not overwrite the newer ALU value.
REQ-024 SHALL treat a load accepted in the same cycle as an ALU write to the same loc as older, and discard it.
REQ-025 SHALL pop killed entries at the head one per cycle without issuing them (do_write=0 that cycle); only live entries set busy_mask bits.
REQ-026 SHALL compute busy_mask combinationally from queue state: OR of one-hot(loc) over live entries.
REQ-027 SHALL wrap head and tail pointers modulo DEPTH; empty is detected by head==tail with count=0, full by count=DEPTH.
REQ-028 SHALL impose no fairness guarantee: sustained alu_valid starves the queue; mem_ready then falls once the queue fills.

Reset
REQ-029 SHALL, on a rising clock edge with nreset=0, clear the queue (count 0, pointers 0, all live bits 0) and set do_write=0, write_loc=0, write_data=0.
REQ-030 SHALL hold mem_ready=0 while nreset=0, and busy_mask=0 from the first edge after reset is applied; reset mid-operation discards all queued writes with none issued.

Verification
REQ-031 SHALL cover: ALU x5=0x11 with an idle queue -> next cycle do_write=1, write_loc=5, write_data=0x11.
REQ-032 SHALL cover: loads x3=0xA and x4=0xB back-to-back with no ALU -> writes x3 then x4 on consecutive cycles; busy_mask shows bits 3 and 4 set, then clears in order.
REQ-033 SHALL cover: 4 loads with continuous ALU traffic to x1 -> mem_ready=0 after the 4th acceptance; when the ALU stops, 4 writes drain in order and mem_ready returns to 1.
REQ-034 SHALL cover: queued load x7=0x1, then ALU x7=0x2 -> only x7=0x2 is written; the killed entry pops with do_write=0; busy_mask bit 7 clears the cycle after the kill.
REQ-035 SHALL cover: a load to x0 and an ALU write to x0 -> handshake completes, do_write is never 1, and busy_mask stays 0.
REQ-036 SHALL cover: nreset=0 with 3 entries queued -> the next cycle has do_write=0 and busy_mask=0, and no queued write ever issues.
